download_ctrl: RTL

DOWNLOAD_CTRL -- requirements
Module: download_ctrl

---
 rtl/dl_pkg.sv | 15 +
 rtl/hold_timer.sv | 26 ++
 rtl/download_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/dl_pkg.sv
// dl_pkg: shared FSM states, region codes and index-to-region mapping for download_ctrl
package dl_pkg;

    typedef enum logic [2:0] {IDLE, ARMED, WRITE, FINISH, HOLD} dl_state_t;

    localparam logic [1:0] REG_PROG = 2'd0;
    localparam logic [1:0] REG_CHAR = 2'd1;
    localparam logic [1:0] REG_PAL  = 2'd2;
    localparam logic [7:0] IDX_MAX  = 8'd2;

    function automatic logic [1:0] index_to_region(input logic [7:0] index);
        return index == 8'd0 ? REG_PROG : index == 8'd1 ? REG_CHAR : REG_PAL;
    endfunction

endpackage

// File: rtl/hold_timer.sv
// hold_timer: loadable down-counter that flags the last cycle of a countdown
module hold_timer #(
    parameter int CYCLES = 16
) (
    input  logic clk_sys,
    input  logic reset_n,
    input  logic load,
    input  logic count,
    output logic expire
);

    localparam int W = $clog2(CYCLES + 1);

    logic [W-1:0] cnt;

    // reload on reset or load, otherwise step down while enabled
    always_ff @(posedge clk_sys) begin
        if (!reset_n || load)
            cnt <= W'(CYCLES);
        else if (count && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expire = count && cnt == W'(1);

endmodule

// File: rtl/download_ctrl.sv
// download_ctrl: steers loader bytes into soc memory regions while holding the CPU in reset
module download_ctrl
    import dl_pkg::*;
#(
    parameter int HOLD_CYCLES = 16,
    parameter int ADDR_W      = 14
) (
    input  logic              clk_sys,
    input  logic              reset_n,
    input  logic              ioctl_download,
    input  logic              ioctl_wr,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_dout,
    input  logic [7:0]        ioctl_index,
    output logic              ioctl_wait,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [1:0]        mem_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              cpu_hold,
    output logic              dl_done,
    output logic [14:0]       dl_count,
    output logic              dl_error
);

    dl_state_t  state;
    logic [7:0] index;
    logic       dl_prev;
    logic       rise;
    logic       target_ok;
    logic       hold_expire;

    assign rise      = ioctl_download && !dl_prev;
    assign target_ok = (index <= IDX_MAX) && (ioctl_addr[24:ADDR_W] == '0);

    // counts the post-session hold and the post-reset hold in IDLE
    hold_timer #(.CYCLES(HOLD_CYCLES)) u_hold (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .load    (state == FINISH),
        .count   (state == HOLD || (state == IDLE && cpu_hold)),
        .expire  (hold_expire)
    );

    // session sequencing; every output is a register written here
    always_ff @(posedge clk_sys) begin
        if (!reset_n) begin
            state      <= IDLE;
            index      <= '0;
            dl_prev    <= 1'b0;
            mem_req    <= 1'b0;
            ioctl_wait <= 1'b0;
            mem_sel    <= REG_PROG;
            mem_addr   <= '0;
            mem_data   <= '0;
            cpu_hold   <= 1'b1;
            dl_done    <= 1'b0;
            dl_count   <= '0;
            dl_error   <= 1'b0;
        end else begin
            dl_prev <= ioctl_download;
            dl_done <= 1'b0;
            if (ioctl_wr && ioctl_wait)
                dl_error <= 1'b1;
            case (state)
                IDLE, HOLD: begin
                    if (rise) begin
                        state    <= ARMED;
                        index    <= ioctl_index;
                        dl_count <= '0;
                        dl_error <= 1'b0;
                        cpu_hold <= 1'b1;
                    end else if (hold_expire) begin
                        state    <= IDLE;
                        cpu_hold <= 1'b0;
                    end
                end
                ARMED: begin
                    if (ioctl_wr && target_ok) begin
                        state      <= WRITE;
                        mem_req    <= 1'b1;
                        ioctl_wait <= 1'b1;
                        mem_sel    <= index_to_region(index);
                        mem_addr   <= ioctl_addr[ADDR_W-1:0];
                        mem_data   <= ioctl_dout;
                    end else begin
                        if (ioctl_wr)
                            dl_error <= 1'b1;
                        if (!ioctl_download) begin
                            state   <= FINISH;
                            dl_done <= 1'b1;
                        end
                    end
                end
                WRITE: begin
                    if (mem_ack) begin
                        mem_req    <= 1'b0;
                        ioctl_wait <= 1'b0;
                        dl_count   <= dl_count + 15'(dl_count != 15'h7FFF);
                        state      <= ioctl_download ? ARMED : FINISH;
                        dl_done    <= !ioctl_download;
                    end
                end
                FINISH: state <= HOLD;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
